dmem_port_arbiter: RTL and testbench

- Shares the single-port data RAM between two requesters.
  - Requester 0: the pipelined CPU MEM stage.
  - Requester 1: the program/data loader, a debug/IO DMA master.
- Grants one access per cycle and stalls the CPU pipeline when it loses arbitration.
- Tags the 1-cycle-latency read data back to the requester that issued the read.
- Sits between `pipelined_computer`'s MEM stage and the data RAM instance, clocked by the same `clock` as the pipeline.

---
 rtl/dmem_arb_pkg.sv | 17 +
 rtl/dmem_read_return.sv | 45 ++++
 rtl/dmem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-RAM port arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      CPU_PRI   = 2'd0,
      FORCE     = 2'd1,
      LDR_BURST = 2'd2
   } arb_state_t;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_LDR = 1'b1;

   localparam int BURST_MAX = 16;
   localparam int WAIT_W    = 4;
   localparam int BURST_W   = 5;

endpackage

// File: rtl/dmem_read_return.sv
// Read-return path: tags each granted read and steers the
// one-cycle-late RAM data back to whoever issued it.
module dmem_read_return
   import dmem_arb_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rd_fire,
   input  logic              rd_owner,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              ldr_rvalid
);

   logic              pend;
   logic              own;
   logic [DATA_W-1:0] cpu_hold;
   logic [DATA_W-1:0] ldr_hold;

   assign cpu_rvalid = pend & (own == OWN_CPU);
   assign ldr_rvalid = pend & (own == OWN_LDR);

   // The idle side keeps showing the last word it received.
   assign cpu_rdata = cpu_rvalid ? ram_rdata : cpu_hold;
   assign ldr_rdata = ldr_rvalid ? ram_rdata : ldr_hold;

   always_ff @(posedge clock) begin
      if (reset) begin
         pend     <= 1'b0;
         own      <= OWN_CPU;
         cpu_hold <= '0;
         ldr_hold <= '0;
      end else begin
         pend <= rd_fire;
         own  <= rd_owner;
         if (cpu_rvalid) cpu_hold <= ram_rdata;
         if (ldr_rvalid) ldr_hold <= ram_rdata;
      end
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data RAM between the CPU MEM stage
// and the loader/DMA master, one access per cycle.
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_stall,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   input  logic              ldr_req,
   input  logic              ldr_lock,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic              ldr_gnt,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              ldr_rvalid,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   arb_state_t         state;
   arb_state_t         arb_state;
   logic [WAIT_W-1:0]  wait_cnt;
   logic [WAIT_W-1:0]  wait_inc;
   logic [BURST_W-1:0] burst_cnt;
   logic               cpu_gnt;
   logic               ldr_denied;
   logic               burst_last;

   // Reset arbitrates as CPU_PRI even before the register settles.
   assign arb_state = reset ? CPU_PRI : state;

   always_comb begin
      cpu_gnt = 1'b0;
      ldr_gnt = 1'b0;
      unique case (arb_state)
         FORCE: begin
            ldr_gnt = ldr_req;
         end
         LDR_BURST: begin
            ldr_gnt = ldr_req & (ldr_lock | ~cpu_req);
            cpu_gnt = cpu_req & ~(ldr_req & ldr_lock);
         end
         default: begin
            cpu_gnt = cpu_req;
            ldr_gnt = ldr_req & ~cpu_req;
         end
      endcase
   end

   assign cpu_stall  = cpu_req & ~cpu_gnt;
   assign ram_en     = (cpu_gnt | ldr_gnt) & ~reset;
   assign ram_we     = ram_en & (ldr_gnt ? ldr_we : cpu_we);
   assign ram_addr   = ldr_gnt ? ldr_addr : cpu_addr;
   assign ram_wdata  = ldr_gnt ? ldr_wdata : cpu_wdata;

   assign ldr_denied = ldr_req & ~ldr_gnt;
   assign wait_inc   = (wait_cnt == '1) ? wait_cnt
                                        : wait_cnt + 1'b1;
   assign burst_last = (burst_cnt == BURST_W'(BURST_MAX - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= CPU_PRI;
         wait_cnt  <= '0;
         burst_cnt <= '0;
      end else begin
         wait_cnt <= ldr_denied ? wait_inc : '0;
         unique case (state)
            CPU_PRI: begin
               if (ldr_gnt && ldr_lock) begin
                  state     <= LDR_BURST;
                  burst_cnt <= BURST_W'(1);
               end else if (ldr_denied &&
                            wait_inc >= WAIT_W'(MAX_WAIT)) begin
                  state <= FORCE;
               end
            end
            FORCE: begin
               if (ldr_gnt && ldr_lock) begin
                  state     <= LDR_BURST;
                  burst_cnt <= BURST_W'(1);
               end else begin
                  state     <= CPU_PRI;
                  burst_cnt <= '0;
               end
            end
            LDR_BURST: begin
               // The grant that reaches the cap is the burst's last.
               if (ldr_req && ldr_lock && !burst_last) begin
                  burst_cnt <= burst_cnt + 1'b1;
               end else begin
                  state     <= CPU_PRI;
                  burst_cnt <= '0;
               end
            end
            default: begin
               state     <= CPU_PRI;
               burst_cnt <= '0;
            end
         endcase
      end
   end

   dmem_read_return #(
      .DATA_W(DATA_W)
   ) u_ret (
      .clock     (clock),
      .reset     (reset),
      .rd_fire   (ram_en & ~ram_we),
      .rd_owner  (ldr_gnt ? OWN_LDR : OWN_CPU),
      .ram_rdata (ram_rdata),
      .cpu_rdata (cpu_rdata),
      .cpu_rvalid(cpu_rvalid),
      .ldr_rdata (ldr_rdata),
      .ldr_rvalid(ldr_rvalid)
   );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus random
// traffic against a rule-level arbitration and memory model.
module tb_dmem_port_arbiter;

   localparam int AW = 8;
   localparam int DW = 32;
   localparam int MW = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic          cpu_req, cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_stall, cpu_rvalid;
   logic [DW-1:0] cpu_rdata;
   logic          ldr_req, ldr_lock, ldr_we;
   logic [AW-1:0] ldr_addr;
   logic [DW-1:0] ldr_wdata;
   logic          ldr_gnt, ldr_rvalid;
   logic [DW-1:0] ldr_rdata;
   logic          ram_en, ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata = '0;

   logic [DW-1:0] mem [256];
   logic [DW-1:0] ref_mem [256];
   bit            mem_ready = 1'b0;

   int errors = 0;
   int checks = 0;

   // reference model state
   int            m_wait = 0;
   int            m_run = 0;
   bit            m_force = 1'b0;
   bit            m_burst = 1'b0;
   bit            p_valid = 1'b0;
   bit            p_own = 1'b0;
   logic [DW-1:0] p_data = '0;
   logic [DW-1:0] h_cpu = '0;
   logic [DW-1:0] h_ldr = '0;
   bit            e_stall = 1'b0;
   bit            o_ldr_gnt, o_cpu_gnt, o_ram_en;

   always #5 clock = ~clock;

   dmem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_stall (cpu_stall),
      .cpu_rdata (cpu_rdata),
      .cpu_rvalid(cpu_rvalid),
      .ldr_req   (ldr_req),
      .ldr_lock  (ldr_lock),
      .ldr_we    (ldr_we),
      .ldr_addr  (ldr_addr),
      .ldr_wdata (ldr_wdata),
      .ldr_gnt   (ldr_gnt),
      .ldr_rdata (ldr_rdata),
      .ldr_rvalid(ldr_rvalid),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   function automatic logic [DW-1:0] seed(input int i);
      return 32'hA5A5_0000 | 32'(i);
   endfunction

   always @(posedge clock) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) mem[i] <= seed(i);
         mem_ready <= 1'b1;
      end else if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata <= mem[ram_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // 0 = nobody, 1 = CPU, 2 = loader
   function automatic int pick();
      if (!reset && m_force) return ldr_req ? 2 : 0;
      if (!reset && m_burst && ldr_req && ldr_lock) return 2;
      if (cpu_req) return 1;
      return ldr_req ? 2 : 0;
   endfunction

   task automatic cyc();
      int            win;
      bit            en_e, we_e, denied, nf;
      logic [AW-1:0] a_e;
      logic [DW-1:0] d_e, exp_c, exp_l;
      @(negedge clock);
      win     = pick();
      en_e    = (win != 0) && !reset;
      we_e    = (win == 2) ? ldr_we : cpu_we;
      a_e     = (win == 2) ? ldr_addr : cpu_addr;
      d_e     = (win == 2) ? ldr_wdata : cpu_wdata;
      e_stall = cpu_req && (win != 1);
      o_ldr_gnt = ldr_gnt;
      o_cpu_gnt = cpu_req & ~cpu_stall;
      o_ram_en  = ram_en;
      chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
      chk("ldr_gnt", 32'(ldr_gnt), 32'(win == 2));
      chk("ram_en", 32'(ram_en), 32'(en_e));
      if (en_e) begin
         chk("ram_we", 32'(ram_we), 32'(we_e));
         chk("ram_addr", 32'(ram_addr), 32'(a_e));
         if (we_e) chk("ram_wdata", ram_wdata, d_e);
      end
      exp_c = (p_valid && !p_own) ? p_data : h_cpu;
      exp_l = (p_valid && p_own) ? p_data : h_ldr;
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(p_valid && !p_own));
      chk("ldr_rvalid", 32'(ldr_rvalid), 32'(p_valid && p_own));
      chk("cpu_rdata", cpu_rdata, exp_c);
      chk("ldr_rdata", ldr_rdata, exp_l);
      @(posedge clock);
      if (reset) begin
         m_wait = 0; m_run = 0; m_force = 0; m_burst = 0;
         p_valid = 0; h_cpu = '0; h_ldr = '0;
      end else begin
         if (p_valid) begin
            if (p_own) h_ldr = p_data;
            else       h_cpu = p_data;
         end
         p_valid = 0;
         if (en_e) begin
            if (we_e) ref_mem[a_e] = d_e;
            else begin
               p_valid = 1; p_own = (win == 2); p_data = ref_mem[a_e];
            end
         end
         denied = ldr_req && (win != 2);
         m_wait = denied ? ((m_wait < 15) ? m_wait + 1 : 15) : 0;
         nf = !m_force && !m_burst && denied && (m_wait >= MW);
         m_run = (win == 2 && ldr_lock) ? m_run + 1 : 0;
         m_burst = (m_run > 0) && (m_run < 16);
         if (m_run >= 16) m_run = 0;
         m_force = nf;
      end
      #1;
   endtask

   initial begin
      int widx, run, first_run, cpu_grants;
      bit cpu_done;
      for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);

      // reset with both requesters active
      reset = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 8'h05;
      cpu_wdata = '0; ldr_req = 1; ldr_lock = 1; ldr_we = 0;
      ldr_addr = 8'h06; ldr_wdata = '0;
      for (int n = 0; n < 3; n++) begin
         cyc();
         chk("reset_ram_en", 32'(o_ram_en), 32'd0);
      end
      chk("reset_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      chk("reset_ldr_rvalid", 32'(ldr_rvalid), 32'd0);

      // routine CPU write then read
      reset = 0; ldr_req = 0; ldr_lock = 0;
      cpu_req = 1; cpu_we = 1; cpu_addr = 8'h10;
      cpu_wdata = 32'hDEAD_BEEF;
      cyc();
      cpu_we = 0;
      cyc();
      chk("routine_gnt", 32'(o_cpu_gnt), 32'd1);
      chk("routine_rvalid", 32'(cpu_rvalid), 32'd1);
      chk("routine_rdata", cpu_rdata, 32'hDEAD_BEEF);
      cpu_req = 0;
      cyc();

      // contention: loader forced in every fifth cycle
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
      ldr_req = 1; ldr_lock = 0; ldr_we = 1; ldr_addr = 8'h40;
      ldr_wdata = 32'h0BAD_F00D;
      for (int n = 0; n < 15; n++) begin
         cyc();
         chk("contend_ldr", 32'(o_ldr_gnt), 32'(n % 5 == 4));
         chk("contend_cpu", 32'(o_cpu_gnt), 32'(n % 5 != 4));
      end
      cpu_req = 0; ldr_req = 0;
      cyc();

      // locked burst of 20 writes, CPU asks from word 3
      widx = 0; run = 0; first_run = 0; cpu_grants = 0; cpu_done = 0;
      ldr_req = 1; ldr_lock = 1; ldr_we = 1;
      cpu_we = 0; cpu_addr = 8'h10;
      for (int n = 0; n < 60 && widx < 20; n++) begin
         ldr_addr  = 8'h80 + 8'(widx);
         ldr_wdata = 32'hB000_0000 + 32'(widx);
         if (widx == 3 && !cpu_done) cpu_req = 1;
         cyc();
         if (o_ldr_gnt) begin
            widx++; run++;
         end else begin
            if (first_run == 0) first_run = run;
            run = 0;
         end
         if (o_cpu_gnt) begin
            cpu_grants++; cpu_req = 0; cpu_done = 1;
         end
      end
      chk("burst_len", 32'(first_run), 32'd16);
      chk("burst_cpu_gnts", 32'(cpu_grants), 32'd1);
      chk("burst_words", 32'(widx), 32'd20);
      ldr_req = 0; ldr_lock = 0;
      cyc();

      // read routing
      ldr_req = 1; ldr_we = 1; ldr_addr = 8'h20; ldr_wdata = 32'h1234;
      cyc();
      ldr_req = 0;
      cpu_req = 1; cpu_we = 1; cpu_addr = 8'h21; cpu_wdata = 32'h5678;
      cyc();
      cpu_req = 0;
      ldr_req = 1; ldr_we = 0; ldr_addr = 8'h20;
      cyc();
      chk("route_ldr_rvalid", 32'(ldr_rvalid), 32'd1);
      chk("route_ldr_rdata", ldr_rdata, 32'h1234);
      chk("route_cpu_quiet", 32'(cpu_rvalid), 32'd0);
      ldr_req = 0;
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h21;
      cyc();
      chk("route_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
      chk("route_cpu_rdata", cpu_rdata, 32'h5678);
      chk("route_ldr_quiet", 32'(ldr_rvalid), 32'd0);
      chk("route_ldr_hold", ldr_rdata, 32'h1234);
      cpu_req = 0;
      cyc();

      // reset in the middle of a locked read burst
      ldr_req = 1; ldr_lock = 1; ldr_we = 0; ldr_addr = 8'h20;
      for (int n = 0; n < 3; n++) cyc();
      reset = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 8'h21;
      cyc();
      chk("rst_mid_en", 32'(o_ram_en), 32'd0);
      chk("rst_mid_rvalid", 32'(ldr_rvalid), 32'd0);
      reset = 0;
      cyc();
      chk("rst_mid_cpu_gnt", 32'(o_cpu_gnt), 32'd1);
      cpu_req = 0; ldr_req = 0; ldr_lock = 0;
      cyc();

      // random traffic
      for (int n = 0; n < 400; n++) begin
         reset = ($urandom_range(0, 99) == 0);
         if (!e_stall) begin
            cpu_req   = ($urandom_range(0, 2) != 0);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = 8'($urandom_range(0, 31));
            cpu_wdata = $urandom;
         end
         ldr_req   = 1'($urandom_range(0, 1));
         ldr_lock  = ($urandom_range(0, 3) != 0);
         ldr_we    = 1'($urandom_range(0, 1));
         ldr_addr  = 8'($urandom_range(0, 31));
         ldr_wdata = $urandom;
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
